// File: rtl/gate_alu_arbiter_pkg.sv
// rtl/gate_alu_arbiter_pkg.sv - opcode and FSM state types shared by the gate ALU arbiter
package gate_alu_arbiter_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOT  = 3'b110,
        OP_BUF  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_e;

endpackage

// File: rtl/gate_alu_rr_pick.sv
// rtl/gate_alu_rr_pick.sv - combinational round-robin picker starting one past ptr
module gate_alu_rr_pick #(
    parameter  int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    logic [ID_W-1:0] cand;

    // Scan from the farthest offset down so the nearest set request after ptr wins last.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = ID_W'((int'(ptr) + k) % NREQ);
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                idx         = cand;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gate_alu_arbiter.sv
// rtl/gate_alu_arbiter.sv - round-robin shared bitwise logic unit; optional GATE_ALU_ARBITER_GRANT_CNT_EN adds grant_cnt
module gate_alu_arbiter
    import gate_alu_arbiter_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 4,
    localparam int ID_W  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [OP_W*NREQ-1:0]  req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
`ifdef GATE_ALU_ARBITER_GRANT_CNT_EN
    output logic [7:0]            grant_cnt,
`endif
    output logic                  busy
);

    state_e          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    op_e             op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            busy_q, busy_d;
    logic [WIDTH-1:0] alu_res;

    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] win;
    logic            any;
    logic            accept;

    gate_alu_rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (win),
        .any   (any)
    );

    // Grants are only offered from IDLE and never while reset is held.
    assign accept    = (state_q == ST_IDLE) && any && rst_n;
    assign req_ready = accept ? grant : '0;

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign busy      = busy_q;

    // Bitwise operation on the operands latched at accept time.
    always_comb begin
        alu_res = '0;
        unique case (op_q)
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_NAND: alu_res = ~(a_q & b_q);
            OP_NOR:  alu_res = ~(a_q | b_q);
            OP_XNOR: alu_res = ~(a_q ^ b_q);
            OP_NOT:  alu_res = ~a_q;
            OP_BUF:  alu_res = a_q;
            default: alu_res = '0;
        endcase
    end

    // Next-state: IDLE latches the winner, EXEC computes once, RESP holds until taken.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        data_d      = data_q;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = op_e'(req_op[int'(win)*OP_W +: OP_W]);
                    a_d     = req_a[int'(win)*WIDTH +: WIDTH];
                    b_d     = req_b[int'(win)*WIDTH +: WIDTH];
                    id_d    = win;
                    ptr_d   = win;
                    state_d = ST_EXEC;
                    busy_d  = 1'b1;
                end
            end
            ST_EXEC: begin
                data_d      = alu_res;
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= ID_W'(NREQ - 1);
            id_q        <= '0;
            op_q        <= OP_AND;
            a_q         <= '0;
            b_q         <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef GATE_ALU_ARBITER_GRANT_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    // Accept counter, wraps naturally at 8 bits.
    always_comb begin
        cnt_d = cnt_q;
        if (accept) cnt_d = cnt_q + 8'd1;
    end

    // Accept counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end

    assign grant_cnt = cnt_q;
`endif

endmodule
